// File: rtl/alu_seq_pkg.sv
// Shared ALU encodings: FSM states, operation codes, P-register bit positions.
// Pure declarations; no logic, no latency, no flow control.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        C_ALU_ST_IDLE = 2'd0,
        C_ALU_ST_ADJ  = 2'd1,
        C_ALU_ST_HOLD = 2'd2
    } alu_st_e;

    localparam logic [3:0] C_ALU_CTRL_THA = 4'h0;
    localparam logic [3:0] C_ALU_CTRL_AND = 4'h1;
    localparam logic [3:0] C_ALU_CTRL_ORA = 4'h2;
    localparam logic [3:0] C_ALU_CTRL_EOR = 4'h3;
    localparam logic [3:0] C_ALU_CTRL_ADC = 4'h4;
    localparam logic [3:0] C_ALU_CTRL_SBC = 4'h5;
    localparam logic [3:0] C_ALU_CTRL_CMP = 4'h6;
    localparam logic [3:0] C_ALU_CTRL_BIT = 4'h7;
    localparam logic [3:0] C_ALU_CTRL_INC = 4'h8;
    localparam logic [3:0] C_ALU_CTRL_DEC = 4'h9;
    localparam logic [3:0] C_ALU_CTRL_ASL = 4'hA;
    localparam logic [3:0] C_ALU_CTRL_LSR = 4'hB;
    localparam logic [3:0] C_ALU_CTRL_ROL = 4'hC;
    localparam logic [3:0] C_ALU_CTRL_ROR = 4'hD;

    localparam int C_FLAG_SHFT_C = 0;
    localparam int C_FLAG_SHFT_Z = 1;
    localparam int C_FLAG_SHFT_I = 2;
    localparam int C_FLAG_SHFT_D = 3;
    localparam int C_FLAG_SHFT_B = 4;
    localparam int C_FLAG_SHFT_V = 6;
    localparam int C_FLAG_SHFT_N = 7;

    function automatic logic is_addsub(input logic [3:0] ctrl);
        return (ctrl == C_ALU_CTRL_ADC) || (ctrl == C_ALU_CTRL_SBC);
    endfunction

endpackage

// File: rtl/alu_seq_bcd_adjust.sv
// Combinational per-digit BCD correction of a binary add/sub result; zero latency.
// No flow control: the caller registers the output in its ADJ state.
module alu_seq_bcd_adjust #(
    parameter int DW = 8
) (
    input  logic [DW-1:0]   i_sum,
    input  logic [DW/4-1:0] i_nib_c,
    input  logic            i_sub,
    output logic [DW-1:0]   o_res,
    output logic            o_carry
);

    localparam int ND = DW / 4;

    logic [4:0] w_t;
    logic       w_extra;
    logic       w_dc;

    always_comb begin
        o_res   = '0;
        o_carry = 1'b0;
        w_t     = '0;
        w_extra = 1'b0;
        w_dc    = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (i_sub) begin
                // A borrowing digit wrapped by 16 instead of 10: take 6 back off.
                o_res[4*i +: 4] = i_nib_c[i] ? i_sum[4*i +: 4] : i_sum[4*i +: 4] + 4'hA;
                w_dc            = i_nib_c[i];
            end else begin
                // w_extra is a decimal carry from the digit below that the binary adder never saw.
                w_t             = {1'b0, i_sum[4*i +: 4]} + {4'b0, w_extra};
                w_dc            = i_nib_c[i] | w_t[4] | (w_t[3:0] > 4'd9);
                o_res[4*i +: 4] = w_t[3:0] + (w_dc ? 4'd6 : 4'd0);
                w_extra         = w_dc & ~i_nib_c[i];
            end
            o_carry = w_dc;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered 6502-style ALU with BCD ADC/SBC: 1 cycle binary, 2 cycles decimal.
// Result held until OUT_READY; a new op may be accepted in the same cycle as the drain.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DW     = 8,
    parameter int DEC_EN = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [7:0]    i_flag_in,
    input  logic [3:0]    i_ctrl,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out,
    output logic [7:0]    o_flag_out
);

    localparam int ND  = DW / 4;
    localparam int MSB = DW - 1;

    alu_st_e         r_state;
    alu_st_e         w_state_nxt;
    logic [DW-1:0]   r_out;
    logic [7:0]      r_flag_out;
    logic [ND-1:0]   r_nib_c;
    logic            r_sub;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_dec;
    logic            w_sub;
    logic            w_cin;
    logic            w_chain;
    logic            w_cout;
    logic            w_ovf;
    logic [4:0]      w_nib_t;
    logic [DW-1:0]   w_bb;
    logic [DW-1:0]   w_sum;
    logic [ND-1:0]   w_nib_c;
    logic [DW-1:0]   w_res;
    logic [7:0]      w_flg;
    logic            w_nz_upd;
    logic [DW-1:0]   w_nz_src;
    logic [DW-1:0]   w_adj_res;
    logic            w_adj_c;

    // Nibble-chained adder so the BCD stage gets every digit carry for free.
    always_comb begin
        w_sub   = (i_ctrl == C_ALU_CTRL_SBC) || (i_ctrl == C_ALU_CTRL_CMP);
        w_bb    = w_sub ? ~i_b : i_b;
        w_cin   = (i_ctrl == C_ALU_CTRL_CMP) ? 1'b1 : i_flag_in[C_FLAG_SHFT_C];
        w_sum   = '0;
        w_nib_c = '0;
        w_nib_t = '0;
        w_chain = w_cin;
        for (int i = 0; i < ND; i++) begin
            w_nib_t         = {1'b0, i_a[4*i +: 4]} + {1'b0, w_bb[4*i +: 4]} + {4'b0, w_chain};
            w_sum[4*i +: 4] = w_nib_t[3:0];
            w_nib_c[i]      = w_nib_t[4];
            w_chain         = w_nib_t[4];
        end
    end

    assign w_cout = w_nib_c[ND-1];
    assign w_ovf  = (i_a[MSB] == w_bb[MSB]) & (w_sum[MSB] != i_a[MSB]);
    assign w_dec  = (DEC_EN != 0) && i_flag_in[C_FLAG_SHFT_D] && is_addsub(i_ctrl);

    always_comb begin
        w_res    = i_a;
        w_flg    = i_flag_in;
        w_nz_upd = 1'b1;
        w_nz_src = '0;
        case (i_ctrl)
            C_ALU_CTRL_THA: w_nz_upd = 1'b0;
            C_ALU_CTRL_BIT: begin
                w_nz_upd              = 1'b0;
                w_flg[C_FLAG_SHFT_N]  = i_b[MSB];
                w_flg[C_FLAG_SHFT_V]  = i_b[MSB-1];
                w_flg[C_FLAG_SHFT_Z]  = ~|(i_a & i_b);
            end
            C_ALU_CTRL_CMP: w_flg[C_FLAG_SHFT_C] = w_cout;
            C_ALU_CTRL_ADC,
            C_ALU_CTRL_SBC: begin
                w_res                 = w_sum;
                w_flg[C_FLAG_SHFT_C]  = w_cout;
                w_flg[C_FLAG_SHFT_V]  = w_ovf;
            end
            C_ALU_CTRL_INC: w_res = i_a + DW'(1);
            C_ALU_CTRL_DEC: w_res = i_a - DW'(1);
            C_ALU_CTRL_ASL: begin
                w_res                 = {i_a[MSB-1:0], 1'b0};
                w_flg[C_FLAG_SHFT_C]  = i_a[MSB];
            end
            C_ALU_CTRL_LSR: begin
                w_res                 = {1'b0, i_a[MSB:1]};
                w_flg[C_FLAG_SHFT_C]  = i_a[0];
            end
            C_ALU_CTRL_ROL: begin
                w_res                 = {i_a[MSB-1:0], i_flag_in[C_FLAG_SHFT_C]};
                w_flg[C_FLAG_SHFT_C]  = i_a[MSB];
            end
            C_ALU_CTRL_ROR: begin
                w_res                 = {i_flag_in[C_FLAG_SHFT_C], i_a[MSB:1]};
                w_flg[C_FLAG_SHFT_C]  = i_a[0];
            end
            C_ALU_CTRL_AND: w_res = i_a & i_b;
            C_ALU_CTRL_ORA: w_res = i_a | i_b;
            C_ALU_CTRL_EOR: w_res = i_a ^ i_b;
            default:        w_res = i_a;
        endcase
        // CMP reports A but flags the difference.
        if (w_nz_upd) begin
            w_nz_src             = (i_ctrl == C_ALU_CTRL_CMP) ? w_sum : w_res;
            w_flg[C_FLAG_SHFT_N] = w_nz_src[MSB];
            w_flg[C_FLAG_SHFT_Z] = ~|w_nz_src;
        end
    end

    alu_seq_bcd_adjust #(
        .DW (DW)
    ) u_bcd_adjust (
        .i_sum   (r_out),
        .i_nib_c (r_nib_c),
        .i_sub   (r_sub),
        .o_res   (w_adj_res),
        .o_carry (w_adj_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= C_ALU_ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            C_ALU_ST_IDLE: w_in_ready = 1'b1;
            C_ALU_ST_ADJ:  w_state_nxt = C_ALU_ST_HOLD;
            C_ALU_ST_HOLD: begin
                w_in_ready = i_out_ready;
                if (i_out_ready) w_state_nxt = C_ALU_ST_IDLE;
            end
            default:       w_state_nxt = C_ALU_ST_IDLE;
        endcase
        w_accept = i_in_valid & w_in_ready;
        if (w_accept) w_state_nxt = w_dec ? C_ALU_ST_ADJ : C_ALU_ST_HOLD;
    end

    // Decimal ops park the binary sum in r_out and finish it during ADJ.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out      <= '0;
            r_flag_out <= '0;
            r_nib_c    <= '0;
            r_sub      <= 1'b0;
        end else if (w_accept) begin
            r_out      <= w_res;
            r_flag_out <= w_flg;
            r_nib_c    <= w_nib_c;
            r_sub      <= (i_ctrl == C_ALU_CTRL_SBC);
        end else if (r_state == C_ALU_ST_ADJ) begin
            r_out                     <= w_adj_res;
            r_flag_out[C_FLAG_SHFT_C] <= w_adj_c;
            r_flag_out[C_FLAG_SHFT_N] <= w_adj_res[MSB];
            r_flag_out[C_FLAG_SHFT_Z] <= ~|w_adj_res;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = (r_state == C_ALU_ST_HOLD);
    assign o_out       = r_out;
    assign o_flag_out  = r_flag_out;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at DW=8 and DW=16 with hand-computed expectations.
module tb_alu_seq;

    localparam logic [3:0] THA = 4'h0, AND = 4'h1, EOR = 4'h3, ADC = 4'h4, SBC = 4'h5;
    localparam logic [3:0] CMP = 4'h6, BIT = 4'h7, INC = 4'h8, ROR = 4'hD, UND = 4'hF;

    logic        clk;
    logic        rst_n;

    logic        v8, rdy8, ov8, ordy8;
    logic [7:0]  a8, b8, fl8, out8, flo8;
    logic [3:0]  c8;

    logic        v16, rdy16, ov16, ordy16;
    logic [15:0] a16, b16, out16;
    logic [7:0]  fl16, flo16;
    logic [3:0]  c16;

    int          n_checks;
    int          n_fail;

    alu_seq #(.DW(8), .DEC_EN(1)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v8), .o_in_ready(rdy8),
        .i_a(a8), .i_b(b8), .i_flag_in(fl8), .i_ctrl(c8),
        .o_out_valid(ov8), .i_out_ready(ordy8), .o_out(out8), .o_flag_out(flo8)
    );

    alu_seq #(.DW(16), .DEC_EN(1)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v16), .o_in_ready(rdy16),
        .i_a(a16), .i_b(b16), .i_flag_in(fl16), .i_ctrl(c16),
        .o_out_valid(ov16), .i_out_ready(ordy16), .o_out(out16), .o_flag_out(flo16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: present, wait for accept, count cycles to OUT_VALID, drain.
    task automatic run_op(input bit wide, input logic [3:0] ctrl, input logic [15:0] a,
                          input logic [15:0] b, input logic [7:0] fl,
                          output logic [15:0] o, output logic [7:0] f, output int lat);
        int n;
        @(negedge clk);
        if (wide) begin v16 = 1'b1; a16 = a; b16 = b; c16 = ctrl; fl16 = fl; end
        else      begin v8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; c8 = ctrl; fl8 = fl; end
        n = 0;
        while (!(wide ? rdy16 : rdy8) && n < 20) begin @(negedge clk); n++; end
        check("in_ready", wide ? rdy16 : rdy8, 1'b1);
        @(posedge clk);
        #1;
        v8  = 1'b0;
        v16 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(wide ? ov16 : ov8) && lat < 10);
        o = wide ? out16 : {8'h00, out8};
        f = wide ? flo16 : flo8;
        if (wide) ordy16 = 1'b1; else ordy8 = 1'b1;
        @(posedge clk);
        #1;
        ordy8  = 1'b0;
        ordy16 = 1'b0;
    endtask

    logic [15:0] o;
    logic [7:0]  f;
    int          lat;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; fl8 = '0; c8 = '0; ordy8 = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; fl16 = '0; c16 = '0; ordy16 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ov", ov8, 1'b0);
        check("rst_out", out8, 8'h00);
        check("rst_flag", flo8, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy", rdy8, 1'b1);

        run_op(1'b0, ADC, 16'h50, 16'h50, 8'h20, o, f, lat);
        check("adc_bin_out", o, 16'hA0); check("adc_bin_flg", f, 8'hE0); check("adc_bin_lat", lat, 1);
        run_op(1'b0, ADC, 16'h58, 16'h46, 8'h29, o, f, lat);
        check("adc_dec_out", o, 16'h05); check("adc_dec_flg", f, 8'h69); check("adc_dec_lat", lat, 2);
        run_op(1'b0, SBC, 16'h46, 16'h12, 8'h29, o, f, lat);
        check("sbc_dec1_out", o, 16'h34); check("sbc_dec1_flg", f, 8'h29);
        run_op(1'b0, SBC, 16'h12, 16'h21, 8'h29, o, f, lat);
        check("sbc_dec2_out", o, 16'h91); check("sbc_dec2_flg", f, 8'hA8); check("sbc_dec2_lat", lat, 2);
        run_op(1'b0, CMP, 16'h10, 16'h10, 8'h20, o, f, lat);
        check("cmp_eq_out", o, 16'h10); check("cmp_eq_flg", f, 8'h23);
        run_op(1'b0, CMP, 16'h0F, 16'h10, 8'h20, o, f, lat);
        check("cmp_lt_out", o, 16'h0F); check("cmp_lt_flg", f, 8'hA0);
        run_op(1'b0, BIT, 16'h0F, 16'hC0, 8'h20, o, f, lat);
        check("bit_out", o, 16'h0F); check("bit_flg", f, 8'hE2);
        run_op(1'b0, ROR, 16'h01, 16'h00, 8'h21, o, f, lat);
        check("ror_out", o, 16'h80); check("ror_flg", f, 8'hA1);
        run_op(1'b0, THA, 16'h00, 16'h00, 8'h82, o, f, lat);
        check("tha_out", o, 16'h00); check("tha_flg", f, 8'h82);
        run_op(1'b0, AND, 16'hF0, 16'h3C, 8'h08, o, f, lat);
        check("and_d_out", o, 16'h30); check("and_d_flg", f, 8'h08); check("and_d_lat", lat, 1);
        run_op(1'b0, INC, 16'hFF, 16'h00, 8'h41, o, f, lat);
        check("inc_out", o, 16'h00); check("inc_flg", f, 8'h43);
        run_op(1'b0, UND, 16'h80, 16'h00, 8'h02, o, f, lat);
        check("und_out", o, 16'h80); check("und_flg", f, 8'h80);

        // Backpressure, then drain and accept in the same cycle.
        @(negedge clk);
        v8 = 1'b1; a8 = 8'h01; b8 = 8'h02; c8 = ADC; fl8 = 8'h00;
        @(posedge clk);
        #1;
        a8 = 8'hFF; b8 = 8'h0F; c8 = EOR;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ov", ov8, 1'b1);
            check("bp_out", out8, 8'h03);
            check("bp_flg", flo8, 8'h00);
            check("bp_rdy", rdy8, 1'b0);
        end
        @(negedge clk);
        ordy8 = 1'b1;
        #1;
        check("b2b_rdy", rdy8, 1'b1);
        @(posedge clk);
        #1;
        v8 = 1'b0;
        ordy8 = 1'b0;
        @(negedge clk);
        check("b2b_ov", ov8, 1'b1);
        check("b2b_out", out8, 8'hF0);
        check("b2b_flg", flo8, 8'h80);
        ordy8 = 1'b1;
        @(posedge clk);
        #1;
        ordy8 = 1'b0;

        // Reset while a decimal op sits in ADJ.
        @(negedge clk);
        v8 = 1'b1; a8 = 8'h58; b8 = 8'h46; c8 = ADC; fl8 = 8'h29;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("adjrst_ov", ov8, 1'b0);
        check("adjrst_out", out8, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("adjrst_rdy", rdy8, 1'b1);
        check("adjrst_ov2", ov8, 1'b0);

        run_op(1'b1, ADC, 16'h9999, 16'h0001, 8'h28, o, f, lat);
        check("w16_dec_out", o, 16'h0000); check("w16_dec_flg", f, 8'h2B); check("w16_dec_lat", lat, 2);
        run_op(1'b1, ADC, 16'h7FFF, 16'h0001, 8'h20, o, f, lat);
        check("w16_bin_out", o, 16'h8000); check("w16_bin_flg", f, 8'hE0); check("w16_bin_lat", lat, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
